// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch controller.
// Owns the program counter and drives mem_addr. Each word returned on mem_ins
// is pushed with its address into a small prefetch FIFO. The FIFO head is
// offered to decode over a valid/ready handshake. The controller also handles
// redirects, the fetch enable and out-of-range or misaligned fetch faults.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   run             fetch enable (the queue keeps draining when low)
//   mem_addr        byte address to instruction memory (equals pc)
//   mem_ins         big-endian word read combinationally at mem_addr
//   redirect_valid  load redirect_pc into pc and flush the queue
//   redirect_pc     redirect target
//   ins_valid/ready handshake for the queue head
//   ins, ins_pc     head instruction word and its address
//   fault           high while in the FAULT state
//   fetch_count     accepted instructions (FETCH_CTRL_STATS_EN only)
//   stall_count     cycles with valid high and ready low (FETCH_CTRL_STATS_EN only)
//
// Optional feature macro: FETCH_CTRL_STATS_EN adds the two statistics counters.
module fetch_ctrl #(
    parameter int unsigned MEM_BYTES = 1000,
    parameter int unsigned RESET_PC  = 0,
    parameter int unsigned QDEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_ins,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        ins_valid,
    input  logic        ins_ready,
    output logic [31:0] ins,
    output logic [31:0] ins_pc,
`ifdef FETCH_CTRL_STATS_EN
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count,
`endif
    output logic        fault
);

    localparam int unsigned PTR_W   = $clog2(QDEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam logic [31:0] LAST_PC = 32'(MEM_BYTES - 4);

    typedef enum logic [1:0] {IDLE, FETCH, FAULT} state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } entry_t;

    state_t             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    entry_t             ent_q [QDEPTH];
    entry_t             ent_d [QDEPTH];
    logic               push;
    logic               pop;

    assign mem_addr  = pc_q;
    assign ins_valid = (count_q != '0);
    assign ins       = ent_q[rd_ptr_q].word;
    assign ins_pc    = ent_q[rd_ptr_q].pc;
    assign fault     = (state_q == FAULT);

    // Next-state, pc and queue control; a redirect overrides everything but reset.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        ent_d    = ent_q;
        push     = 1'b0;
        pop      = 1'b0;

        if (redirect_valid) begin
            pc_d     = redirect_pc;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            if (redirect_pc[1:0] != 2'b00) begin
                state_d = FAULT;
            end else if (run) begin
                state_d = FETCH;
            end else begin
                state_d = IDLE;
            end
        end else begin
            pop = ins_valid & ins_ready;
            unique case (state_q)
                IDLE: begin
                    if (run) begin
                        state_d = FETCH;
                    end
                end
                FETCH: begin
                    if (!run) begin
                        state_d = IDLE;
                    end else if (pc_q > LAST_PC) begin
                        state_d = FAULT;
                    end else if ((count_q != CNT_W'(QDEPTH)) || pop) begin
                        // A same-cycle pop frees a slot, sustaining one word per cycle when full.
                        push = 1'b1;
                        pc_d = pc_q + 32'd4;
                    end
                end
                FAULT: begin
                    state_d = FAULT;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase

            if (push) begin
                ent_d[wr_ptr_q] = '{pc: pc_q, word: mem_ins};
            end
            rd_ptr_d = rd_ptr_q + PTR_W'(pop);
            wr_ptr_d = wr_ptr_q + PTR_W'(push);
            count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // State, pc and queue registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            pc_q     <= 32'(RESET_PC);
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ent_q    <= ent_d;
        end
    end

`ifdef FETCH_CTRL_STATS_EN
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] stall_count_q, stall_count_d;

    // Statistics: accepted instructions and back-pressured cycles, both free-running.
    always_comb begin
        fetch_count_d = fetch_count_q + 32'(pop);
        stall_count_d = stall_count_q + 32'(ins_valid & ~ins_ready);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count_q <= '0;
            stall_count_q <= '0;
        end else begin
            fetch_count_q <= fetch_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
    assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Testbench for fetch_ctrl: directed stimulus with a scoreboard of expected
// accepted instructions and a negedge monitor that checks each handshake.
module tb_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic        run;
    logic [31:0] mem_addr;
    logic [31:0] mem_ins;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        ins_valid;
    logic        ins_ready;
    logic [31:0] ins;
    logic [31:0] ins_pc;
    logic        fault;
`ifdef FETCH_CTRL_STATS_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_count;
`endif

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    exp_t sb[$];
    int   total;
    int   passed;

    fetch_ctrl #(.MEM_BYTES(1000), .RESET_PC(0), .QDEPTH(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .run            (run),
        .mem_addr       (mem_addr),
        .mem_ins        (mem_ins),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ins_valid      (ins_valid),
        .ins_ready      (ins_ready),
        .ins            (ins),
        .ins_pc         (ins_pc),
`ifdef FETCH_CTRL_STATS_EN
        .fetch_count    (fetch_count),
        .stall_count    (stall_count),
`endif
        .fault          (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte memory: byte i holds low byte of i XOR 0x5A.
    logic [7:0] imem [0:999];
    initial begin
        for (int i = 0; i < 1000; i++) imem[i] = 8'(i) ^ 8'h5A;
    end

    always_comb begin
        if (mem_addr <= 32'd996)
            mem_ins = {imem[mem_addr], imem[mem_addr + 1], imem[mem_addr + 2], imem[mem_addr + 3]};
        else
            mem_ins = 32'hDEAD_BEEF;
    end

    function automatic logic [31:0] expw(input logic [31:0] a);
        logic [7:0] b0, b1, b2, b3;
        b0 = a[7:0] ^ 8'h5A;
        b1 = 8'(a + 1) ^ 8'h5A;
        b2 = 8'(a + 2) ^ 8'h5A;
        b3 = 8'(a + 3) ^ 8'h5A;
        return {b0, b1, b2, b3};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic expect_ins(input logic [31:0] pc);
        exp_t e;
        e.pc   = pc;
        e.word = expw(pc);
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: a handshake that is not cancelled by redirect/reset must match the scoreboard head.
    always @(negedge clk) begin
        if (!rst && ins_valid && ins_ready && !redirect_valid) begin
            total++;
            if (sb.size() == 0) begin
                $display("FAIL sb_extra: got pc %h word %h expected no instruction", ins_pc, ins);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (ins_pc === e.pc && ins === e.word) passed++;
                else $display("FAIL sb_pop: got pc %h word %h expected pc %h word %h",
                              ins_pc, ins, e.pc, e.word);
            end
        end
    end

    initial begin
        total = 0;
        passed = 0;
        rst = 1'b1;
        run = 1'b0;
        ins_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'd0;
        tick();
        tick();
        chk("rst_valid", 32'(ins_valid), 32'd0);
        chk("rst_ins", ins, 32'd0);
        chk("rst_ins_pc", ins_pc, 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);

        // Streaming fetch with decode always ready.
        rst = 1'b0;
        run = 1'b1;
        ins_ready = 1'b1;
        expect_ins(0); expect_ins(4); expect_ins(8); expect_ins(12);
        tick();
        chk("first_lat_idle", 32'(ins_valid), 32'd0);
        tick();
        chk("first_valid", 32'(ins_valid), 32'd1);
        chk("first_pc", ins_pc, 32'd0);
        repeat (4) tick();

        // Restart at 0, then back-pressure for 5 cycles.
        ins_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'd0;
        tick();
        redirect_valid = 1'b0;
        chk("redir0_flush", 32'(ins_valid), 32'd0);
        tick();
        chk("redir0_valid", 32'(ins_valid), 32'd1);
        repeat (5) tick();
        chk("full_pc_hold", mem_addr, 32'd8);
        chk("full_head_pc", ins_pc, 32'd0);
        chk("full_head_w0", ins, 32'h5A5B5859);
        chk("full_valid", 32'(ins_valid), 32'd1);
        ins_ready = 1'b1;
        expect_ins(0); expect_ins(4); expect_ins(8);
        tick();
        chk("b2b_valid1", 32'(ins_valid), 32'd1);
        chk("b2b_pc1", ins_pc, 32'd4);
        tick();
        chk("b2b_valid2", 32'(ins_valid), 32'd1);
        chk("b2b_pc2", ins_pc, 32'd8);
        tick();

        // Redirect to 0x40 with a full queue; stale entries must vanish.
        chk("pre_redir_full_valid", 32'(ins_valid), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        expect_ins(32'h40);
        tick();
        redirect_valid = 1'b0;
        chk("redir40_flush", 32'(ins_valid), 32'd0);
        tick();
        chk("redir40_valid", 32'(ins_valid), 32'd1);
        chk("redir40_pc", ins_pc, 32'h40);
        chk("redir40_word", ins, 32'h1A1B1819);
        tick();

        // Run off the end of memory: 988, 992, 996 fetched, then fault at 1000.
        redirect_valid = 1'b1;
        redirect_pc = 32'd988;
        ins_ready = 1'b0;
        expect_ins(988); expect_ins(992); expect_ins(996);
        tick();
        redirect_valid = 1'b0;
        tick();
        tick();
        chk("end_full_pc", mem_addr, 32'd996);
        ins_ready = 1'b1;
        tick();
        ins_ready = 1'b0;
        chk("end_pre_fault", 32'(fault), 32'd0);
        chk("end_pc_1000", mem_addr, 32'd1000);
        tick();
        chk("end_fault", 32'(fault), 32'd1);
        chk("end_fault_pc", mem_addr, 32'd1000);
        chk("end_fault_head", ins_pc, 32'd992);
        tick();
        tick();
        chk("end_fault_sticky", 32'(fault), 32'd1);
        chk("end_no_push_head", ins_pc, 32'd992);
        ins_ready = 1'b1;
        tick();
        tick();
        chk("end_drained", 32'(ins_valid), 32'd0);
        chk("end_fault_after_drain", 32'(fault), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc = 32'd0;
        expect_ins(0);
        tick();
        redirect_valid = 1'b0;
        chk("fault_clear", 32'(fault), 32'd0);
        tick();
        chk("resume_valid", 32'(ins_valid), 32'd1);
        chk("resume_pc", ins_pc, 32'd0);
        tick();

        // Misaligned redirect, then reset overriding a simultaneous redirect.
        redirect_valid = 1'b1;
        redirect_pc = 32'h6;
        tick();
        redirect_valid = 1'b0;
        chk("misalign_fault", 32'(fault), 32'd1);
        chk("misalign_flush", 32'(ins_valid), 32'd0);
        tick();
        chk("misalign_no_push", 32'(ins_valid), 32'd0);
        chk("misalign_pc", mem_addr, 32'h6);
        rst = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        tick();
        chk("rst2_fault", 32'(fault), 32'd0);
        chk("rst2_pc", mem_addr, 32'd0);
        chk("rst2_valid", 32'(ins_valid), 32'd0);
        rst = 1'b0;
        redirect_valid = 1'b0;
        run = 1'b0;
        ins_ready = 1'b0;
        tick();
        chk("idle_no_fetch", 32'(ins_valid), 32'd0);

`ifdef FETCH_CTRL_STATS_EN
        chk("stats_rst_fetch", fetch_count, 32'd0);
        chk("stats_rst_stall", stall_count, 32'd0);
        run = 1'b1;
        tick();
        tick();
        repeat (3) tick();
        ins_ready = 1'b1;
        expect_ins(0); expect_ins(4); expect_ins(8); expect_ins(12);
        repeat (4) tick();
        run = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        tick();
        redirect_valid = 1'b0;
        tick();
        chk("stats_fetch", fetch_count, 32'd4);
        chk("stats_stall", stall_count, 32'd3);
`endif

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
